// File: rtl/piso_serializer_pkg.sv
// Shared types and frame-geometry helpers for the PISO serializer.
// Build option: PISO_SERIALIZER_PARITY_EN appends an even-parity bit.
package piso_serializer_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_SHIFT = 1'b1;

   localparam int DEF_WIDTH = 4;

   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   function automatic int frame_len(input int width);
`ifdef PISO_SERIALIZER_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

   localparam int CNT_W     = cnt_w(DEF_WIDTH);
   localparam int FRAME_LEN = frame_len(DEF_WIDTH);

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel load handshake plus serial stream outputs.
// slave = serializer side, master = producer/consumer side.
interface piso_serializer_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             sout;
   logic             sout_valid;
   logic             busy;
   logic             frame_done;

   modport slave (
      input  din,
      input  din_valid,
      output din_ready,
      output sout,
      output sout_valid,
      output busy,
      output frame_done
   );

   modport master (
      output din,
      output din_valid,
      input  din_ready,
      input  sout,
      input  sout_valid,
      input  busy,
      input  frame_done
   );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out loader, one bit per clk, zero-gap frames.
// Build option: PISO_SERIALIZER_PARITY_EN appends an even-parity bit.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic               clk,
   input  logic               clr,
   piso_serializer_if.slave   bus
);

   localparam int L_CNT_W = cnt_w(WIDTH);
   localparam int L_FLEN  = frame_len(WIDTH);

   localparam logic [L_CNT_W-1:0] LAST =
      L_CNT_W'(L_FLEN - 1);

`ifdef PISO_SERIALIZER_PARITY_EN
   localparam logic [L_CNT_W-1:0] PAR_IDX =
      L_CNT_W'(WIDTH);
`endif

   state_t             r_state;
   logic [WIDTH-1:0]   r_sr;
   logic [L_CNT_W-1:0] r_cnt;
`ifdef PISO_SERIALIZER_PARITY_EN
   logic               r_par;
`endif

   logic             w_shift;
   logic             w_last;
   logic             w_ready;
   logic             w_accept;
   logic             w_data_bit;
   logic             w_bit;
   logic [WIDTH-1:0] w_sr_next;

   // Handshake and frame-position decode from registered state.
   always_comb begin
      w_shift  = (r_state == ST_SHIFT);
      w_last   = w_shift && (r_cnt == LAST);
      w_ready  = (r_state == ST_IDLE) || w_last;
      w_accept = bus.din_valid && w_ready;
   end

   // Bit selection and one-step shift in the configured order.
   always_comb begin
      w_data_bit = 1'b0;
      w_sr_next  = r_sr;
      if (MSB_FIRST) begin
         w_data_bit = r_sr[WIDTH-1];
         w_sr_next  = {r_sr[WIDTH-2:0], 1'b0};
      end else begin
         w_data_bit = r_sr[0];
         w_sr_next  = {1'b0, r_sr[WIDTH-1:1]};
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      w_bit = (r_cnt == PAR_IDX) ? r_par : w_data_bit;
`else
      w_bit = w_data_bit;
`endif
   end

   // FSM, shift register and bit counter.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= ST_IDLE;
         r_sr    <= '0;
         r_cnt   <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else if (w_accept) begin
         r_state <= ST_SHIFT;
         r_sr    <= bus.din;
         r_cnt   <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
         r_par   <= ^bus.din;
`endif
      end else if (w_shift) begin
         r_sr <= w_sr_next;
         if (w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Outputs depend only on registered state (din_ready aside).
   always_comb begin
      bus.din_ready  = w_ready;
      bus.sout       = w_shift && w_bit;
      bus.sout_valid = w_shift;
      bus.busy       = w_shift;
      bus.frame_done = w_last;
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench with a bit-level scoreboard for two orderings.
// Build option: PISO_SERIALIZER_PARITY_EN expects a parity bit.
module tb_piso_serializer;

   localparam int W = 4;

   typedef struct packed {
      logic b;
      logic last;
   } item_t;

   logic         clk;
   logic         clr;
   logic [W-1:0] din;
   logic         din_valid;

   int errors;
   int checks;

   item_t q_m[$];
   item_t q_l[$];

   piso_serializer_if #(.WIDTH(W)) bm();
   piso_serializer_if #(.WIDTH(W)) bl();

   assign bm.din       = din;
   assign bm.din_valid = din_valid;
   assign bl.din       = din;
   assign bl.din_valid = din_valid;

   piso_serializer #(
      .WIDTH(W),
      .MSB_FIRST(1'b1)
   ) u_msb (
      .clk(clk),
      .clr(clr),
      .bus(bm)
   );

   piso_serializer #(
      .WIDTH(W),
      .MSB_FIRST(1'b0)
   ) u_lsb (
      .clk(clk),
      .clr(clr),
      .bus(bl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] w);
      item_t it;
      for (int i = 0; i < W; i++) begin
`ifdef PISO_SERIALIZER_PARITY_EN
         it.last = 1'b0;
`else
         it.last = (i == W - 1);
`endif
         it.b = w[W-1-i];
         q_m.push_back(it);
         it.b = w[i];
         q_l.push_back(it);
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      it.b    = ^w;
      it.last = 1'b1;
      q_m.push_back(it);
      q_l.push_back(it);
`endif
   endtask

   task automatic check_out();
      logic [3:0] e;
      logic [3:0] o;
      if (q_m.size() != 0)
         e = {q_m[0].b, 1'b1, 1'b1, q_m[0].last};
      else
         e = 4'b0000;
      o = {bm.sout, bm.sout_valid,
           bm.busy, bm.frame_done};
      chk("outs_msb", {4'h0, o}, {4'h0, e});
      if (q_l.size() != 0)
         e = {q_l[0].b, 1'b1, 1'b1, q_l[0].last};
      else
         e = 4'b0000;
      o = {bl.sout, bl.sout_valid,
           bl.busy, bl.frame_done};
      chk("outs_lsb", {4'h0, o}, {4'h0, e});
   endtask

   task automatic cycle(output bit acc);
      bit rdy;
      rdy = (q_m.size() <= 1);
      chk("ready_msb", {7'h0, bm.din_ready}, {7'h0, rdy});
      chk("ready_lsb", {7'h0, bl.din_ready}, {7'h0, rdy});
      acc = din_valid && rdy;
      @(posedge clk);
      if (q_m.size() != 0) void'(q_m.pop_front());
      if (q_l.size() != 0) void'(q_l.pop_front());
      if (acc) push(din);
      #1;
      check_out();
   endtask

   task automatic idle(input int n);
      bit acc;
      din_valid = 1'b0;
      for (int i = 0; i < n; i++) cycle(acc);
   endtask

   task automatic send(input logic [W-1:0] w);
      bit acc;
      din       = w;
      din_valid = 1'b1;
      acc       = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) cycle(acc);
      chk("accept", {7'h0, acc}, 8'h01);
      din_valid = 1'b0;
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      clr       = 1'b1;
      din       = '0;
      din_valid = 1'b0;

      #3;
      check_out();
      #4;
      clr = 1'b0;
      #1;
      chk("ready_rel_m", {7'h0, bm.din_ready}, 8'h01);
      chk("ready_rel_l", {7'h0, bl.din_ready}, 8'h01);
      idle(2);

      send(4'b1011);
      din = 4'b0000;
      idle(W + 2);

      send(4'b1100);
      send(4'b0011);
      idle(W + 2);

      send(4'b1011);
      send(4'b0110);
      din = 4'b1001;
      idle(W + 2);

      send(4'b1111);
      idle(2);
      #2;
      clr = 1'b1;
      #1;
      q_m.delete();
      q_l.delete();
      check_out();
      #2;
      clr = 1'b0;
      idle(3);
      send(4'b0101);
      idle(W + 2);

      send(4'b0001);
      idle(W + 2);

      send(4'b0110);
      send(4'b1001);
      send(4'b1110);
      idle(W + 3);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out loader that feeds the serial data input of the 4-bit shift register stage.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clk cycle, with a qualifying valid flag.
- Supports back-to-back words with no idle gap, giving a continuous serial stream.

Parameters:
- WIDTH, 4, data word width in bits (≥2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 first, 0 = bit 0 first.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous active-high reset
- din  input  WIDTH  parallel word to serialize
- din_valid  input  1  din holds a valid word
- din_ready  output  1  block will accept din on this edge
- sout  output  1  serial data bit, drives the shift register's serial input
- sout_valid  output  1  sout carries a frame bit this cycle
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse coincident with the last bit of a frame

Behaviour:
- One clock (clk); reset clr is asynchronous and active-high. While clr=1, all state is cleared immediately regardless of clk.
- Reset values: state=IDLE, shift reg=0, bit counter=0, sout=0, sout_valid=0, busy=0, frame_done=0, din_ready=1 (after clr deasserts).
- FSM states:
  - IDLE → SHIFT on accept (din_valid & din_ready).
  - SHIFT → SHIFT while bits remain, or on back-to-back accept at the last bit.
  - SHIFT → IDLE after the last bit when no new word is accepted.
- Accept rules:
  - An accept occurs at a rising edge where din_valid=1 and din_ready=1.
  - The word is captured into the internal shift register and the counter is set to 0.
- Latency: word accepted at edge k; bit 0 of the frame is presented during cycle k+1 (after edge k); the last bit is presented in cycle k+WIDTH.
- Bit order: MSB_FIRST=1 presents din[WIDTH-1] down to din[0]; MSB_FIRST=0 presents din[0] up to din[WIDTH-1].
- Outputs: sout, sout_valid, busy and frame_done are functions of registered state only. There is no combinational path from din or din_valid to any output except din_ready.
- din_ready = (state==IDLE) or (state==SHIFT and counter==last index), enabling zero-gap back-to-back frames.
- din_valid while din_ready=0 is ignored. The word is not latched; the producer must hold it.
- In IDLE: sout=0, sout_valid=0, busy=0.
- In SHIFT: sout_valid=1, busy=1.
- frame_done=1 exactly in the cycle the last frame bit is on sout.
- Counter width: clog2(WIDTH+1) bits. It never wraps mid-frame and is reloaded to 0 on every accept.
- Back-to-back: an accept on the last-bit edge starts the next frame's bit 0 in the following cycle. sout_valid stays 1 continuously.
- Reset mid-frame: the frame is abandoned immediately. The next frame requires a fresh accept.
- din changing after accept has no effect on the frame in flight.

Optional Feature:
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined:
  - One even-parity bit (XOR of all WIDTH data bits) is appended after the data bits, so the frame is WIDTH+1 bits.
  - frame_done and din_ready "last index" refer to the parity bit.
  - Latency to the last bit becomes k+WIDTH+1.
- Undefined: the frame is WIDTH data bits only; no parity logic is present.

Decomposition:
- Shared package holds:
  - state typedef (IDLE, SHIFT)
  - localparam CNT_W = clog2(WIDTH+1)
  - constant FRAME_LEN (WIDTH or WIDTH+1 under the macro)
- No sub-module needed. The shift/select datapath and FSM fit in one module. A parity function may live in the package.

Test Plan:
- Reset: assert clr asynchronously mid-cycle → sout=0, sout_valid=0, busy=0, frame_done=0 immediately; din_ready=1 after release.
- Single word, WIDTH=4, MSB_FIRST=1, din=4'b1011 accepted at edge k → sout=1,0,1,1 in cycles k+1..k+4; frame_done high only in k+4; IDLE at k+5.
- Back-to-back: din=4'b1100 then 4'b0011 with din_valid held high → 8 consecutive sout_valid cycles, sout=1,1,0,0,0,0,1,1, frame_done pulses at bits 4 and 8.
- Busy-ignore: second word with din_valid=1 during bits 1–3 → din_ready=0; word not taken until the last-bit edge; stream unchanged.
- Reset mid-frame: clr pulse during bit 2 of 4'b1111 → outputs 0 at once; no resumption; next accepted word 4'b0101 serializes normally.
- MSB_FIRST=0 with din=4'b0001 → sout=1,0,0,0. With PISO_SERIALIZER_PARITY_EN and din=4'b1011 (MSB first) → 1,0,1,1, then parity 1; frame_done on the 5th bit.
